dm_sram_responder: RTL
======================

# dm_sram_responder

Data-side memory responder sitting between the MEM stage's data port and the external asynchronous 32-bit SRAM. It accepts one load or store request at a time and runs a multi-cycle SRAM read or write sequence with explicit setup, pulse and hold phases. While the access is in flight it holds the pipeline with a stall. It returns load data as a full registered word; the MEM stage performs byte and halfword extraction.

## Interface
Parameters:
- ADDR_W, 20, SRAM word-address width; SRAM address = dm_addr_i[ADDR_W+1:2].
- RD_WAIT, 1, cycles spent in RD before sampling read data (≥1).
- WR_PULSE, 1, cycles sram_we_n_o is held low (≥1).

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- dm_addr_i  in  32  byte address from MEM stage.
- dm_wbe_n_i  in  4  active-low byte-lane mask; 4'b1111 = no access.
- dm_wdata_i  in  32  store data, already lane-placed by upstream; written unshifted.
- dm_re_i  in  1  load request.
- dm_we_i  in  1  store request.
- dm_rdata_o  out  32  registered full read word.
- dm_stall_o  out  1  pipeline hold while an access is pending or in progress.
- sram_data_io  inout  32  SRAM data bus.
- sram_addr_o  out  ADDR_W  SRAM word address.
- sram_be_n_o  out  4  SRAM byte enables, active-low.
- sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each  SRAM strobes, active-low.

## Operation
- Request valid (req) = (dm_re_i | dm_we_i) & (dm_wbe_n_i != 4'b1111).
  - MEM gates the mask with its valid, so a raw re/we with an all-ones mask is ignored.
- dm_we_i & dm_re_i both high: treated as a store.
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE:
  - On req, latch addr[ADDR_W+1:2], mask and wdata.
  - Go to WR_SETUP on a store, RD on a load.
  - Otherwise stay.
- RD:
  - ce_n=0, oe_n=0, be_n=4'b0000 (full word regardless of mask), bus high-Z.
  - Counter runs RD_WAIT cycles.
  - On the last cycle, sample sram_data_io into dm_rdata_o and go to DONE.
- WR_SETUP (1 cycle): ce_n=0, oe_n=1, we_n=1, be_n=latched mask, bus driven with latched wdata.
- WR_PULSE (WR_PULSE cycles): as WR_SETUP, with we_n=0.
- WR_HOLD (1 cycle): we_n=1, bus still driven, then go to DONE.
- DONE (1 cycle): all strobes inactive, bus high-Z, stall low so the pipeline advances; then IDLE.
- dm_stall_o = ~rst & ((state==IDLE & req) | state ∈ {RD, WR_SETUP, WR_PULSE, WR_HOLD}).
  - Combinational, so it is asserted in the request's first cycle.
- Bus driven only in WR_SETUP, WR_PULSE and WR_HOLD; never driven in the same cycle as oe_n=0.
- Address bits above ADDR_W+1 are ignored (aliasing); no fault is raised.
- dm_rdata_o holds its last value until the next load completes; stores do not alter it.

## Timing
- Reset values:
  - ce_n=oe_n=we_n=1, be_n=4'b1111, sram_addr_o=0.
  - Bus high-Z, dm_rdata_o=0, dm_stall_o=0, state IDLE, counter 0.
- All SRAM outputs are registered; strobe changes occur on clk edges only.
- Load latency: request in cycle 0 (stall=1); RD in cycles 1..RD_WAIT; DONE in cycle RD_WAIT+1 (stall=0, dm_rdata_o valid). Default is 3 cycles.
- Store latency: cycle 0 accept; 1 SETUP; WR_PULSE cycles PULSE; HOLD; DONE. Default is 5 cycles.
- Back-to-back: the request present in DONE is the already-served one and is not re-accepted. A new request is accepted on the first IDLE cycle after DONE.
- rst asserted in any state: the next edge forces IDLE and reset output values.
  - A write interrupted in WR_PULSE gets we_n=1 on that edge.
  - The bus is released on the same edge.
- Counter width: clog2(max(RD_WAIT, WR_PULSE)) + 1; reloaded on every state entry.

## Test plan
- Reset: hold rst 2 cycles with dm_re_i=1 and mask 0000. All outputs equal their reset values, stall=0, and no strobes go low.
- Word load: SRAM word 0x00001 holds 0x12345678; request dm_addr_i=0x80000004, re=1, mask 0000. Stall is high for 2 cycles, sram_addr_o=0x00001, oe_n is low in RD, and dm_rdata_o=0x12345678 in the DONE cycle.
- Byte store: dm_addr_i=0x80000009, mask 1101, wdata=0x0000AB00. sram_be_n_o=1101, sram_addr_o=0x00002, we_n is low for exactly 1 cycle, data is driven SETUP..HOLD, and the SRAM byte 1 of word 2 becomes 0xAB.
- Ignored request: re=1 with mask 1111 for 5 cycles. Stall stays 0, ce_n stays 1, and the bus stays high-Z.
- Back-to-back store then load to the same address, with RD_WAIT=3 and WR_PULSE=2. Write takes 6 cycles and read takes 5 cycles, and the load returns the stored word.
- Reset in WR_PULSE: we_n=1 and bus high-Z on the next edge, the FSM is in IDLE, and the next load completes normally.

Source files
------------

// File: rtl/dm_sram_responder.sv
// Data-side responder between the MEM-stage data port and an asynchronous 32-bit SRAM.
// One access at a time; registered strobes sequence setup/pulse/hold around each write.
module dm_sram_responder #(
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned RD_WAIT  = 1,
  parameter int unsigned WR_PULSE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dm_addr_i,
  input  logic [3:0]        dm_wbe_n_i,
  input  logic [31:0]       dm_wdata_i,
  input  logic              dm_re_i,
  input  logic              dm_we_i,
  output logic [31:0]       dm_rdata_o,
  output logic              dm_stall_o,
  inout  wire  [31:0]       sram_data_io,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [3:0]        sram_be_n_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o
);

  localparam int unsigned MaxWait = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
  localparam int unsigned CntW    = $clog2(MaxWait) + 1;
  localparam logic [CntW-1:0] RdLoad = CntW'(RD_WAIT - 1);
  localparam logic [CntW-1:0] WrLoad = CntW'(WR_PULSE - 1);

  typedef enum logic [2:0] {
    StIdle, StRd, StWrSetup, StWrPulse, StWrHold, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              req, accept, cnt_last;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_n_q, be_n_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              drive_q, drive_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  assign req      = (dm_re_i | dm_we_i) & (dm_wbe_n_i != 4'b1111);
  assign accept   = (state_q == StIdle) & req;
  assign cnt_last = (cnt_q == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the counter reloads whenever a new state is entered
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (req) state_d = dm_we_i ? StWrSetup : StRd;
      StRd:      if (cnt_last) state_d = StDone;
      StWrSetup: state_d = StWrPulse;
      StWrPulse: if (cnt_last) state_d = StWrHold;
      StWrHold:  state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    cnt_d = cnt_q;
    if (state_d != state_q) begin
      if (state_d == StRd)           cnt_d = RdLoad;
      else if (state_d == StWrPulse) cnt_d = WrLoad;
      else                           cnt_d = '0;
    end else if (!cnt_last) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Output logic: SRAM-side values are computed for the upcoming state and registered
  always_comb begin
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    drive_d = 1'b0;
    be_n_d  = 4'b1111;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    if (accept) begin
      addr_d  = dm_addr_i[ADDR_W+1:2];
      wdata_d = dm_wdata_i;
    end
    if ((state_q == StRd) && cnt_last) rdata_d = sram_data_io;

    unique case (state_d)
      StRd: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = 4'b0000;
      end
      StWrSetup, StWrPulse, StWrHold: begin
        ce_n_d  = 1'b0;
        drive_d = 1'b1;
        we_n_d  = (state_d != StWrPulse);
        be_n_d  = accept ? dm_wbe_n_i : be_n_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      be_n_q  <= 4'b1111;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      drive_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      be_n_q  <= be_n_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      drive_q <= drive_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign dm_stall_o   = ~rst & (accept |
                                (state_q inside {StRd, StWrSetup, StWrPulse, StWrHold}));
  assign dm_rdata_o   = rdata_q;
  assign sram_addr_o  = addr_q;
  assign sram_be_n_o  = be_n_q;
  assign sram_ce_n_o  = ce_n_q;
  assign sram_oe_n_o  = oe_n_q;
  assign sram_we_n_o  = we_n_q;
  assign sram_data_io = drive_q ? wdata_q : 32'hzzzz_zzzz;

endmodule
